// File: rtl/mem_write_checker.sv
// mem_write_checker: self-check monitor for the data-memory write bus.
// Compares observed stores against a programmable table of expected
// (address, data) pairs, tolerates one ignore address and enforces a RUN timeout.
// Optional feature: define MEMCHK_UNORDERED_EN to accept table entries in any order.
module mem_write_checker #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1000,
  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              memwrite_i,
  input  logic [ADDR_W-1:0] dataadr_i,
  input  logic [DATA_W-1:0] writedata_i,
  input  logic              exp_we_i,
  input  logic [IdxW-1:0]   exp_idx_i,
  input  logic [ADDR_W-1:0] exp_addr_i,
  input  logic [DATA_W-1:0] exp_data_i,
  input  logic [CntW-1:0]   exp_count_i,
  input  logic              ign_en_i,
  input  logic [ADDR_W-1:0] ign_addr_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [1:0]        fail_code_o,
  output logic [CntW-1:0]   match_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o
);

  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] tbl_addr_q [DEPTH];
  logic [DATA_W-1:0] tbl_data_q [DEPTH];
  logic [CntW-1:0]   cnt_lat_q;
  logic [CntW-1:0]   match_cnt_q;
  logic [TmrW-1:0]   tmr_q;
  logic              busy_q, pass_q, fail_q;
  logic [1:0]        fail_code_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;

  logic              hit;
  logic              ign_hit;
  logic [CntW-1:0]   match_inc;
  logic [CntW-1:0]   cnt_clamp;

`ifdef MEMCHK_UNORDERED_EN
  logic [DEPTH-1:0]  mask_q;
  logic [IdxW-1:0]   hit_idx;

  // Lowest-index unmatched valid entry equal to the current store.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!hit && (CntW'(i) < cnt_lat_q) && !mask_q[i] &&
          (tbl_addr_q[i] == dataadr_i) && (tbl_data_q[i] == writedata_i)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end
`else
  logic [IdxW-1:0]   cur_idx;

  // Strict ordering: only the entry at match_cnt may match.
  always_comb begin
    cur_idx = match_cnt_q[IdxW-1:0];
    hit     = (tbl_addr_q[cur_idx] == dataadr_i) && (tbl_data_q[cur_idx] == writedata_i);
  end
`endif

  // Ignore-address decode, match increment and start-count clamp.
  always_comb begin
    ign_hit   = ign_en_i && (dataadr_i == ign_addr_i);
    match_inc = match_cnt_q + CntW'(1);
    cnt_clamp = (exp_count_i > CntW'(DEPTH)) ? CntW'(DEPTH) : exp_count_i;
  end

  // Expected-write table; frozen while a run is in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
    end else if (exp_we_i && (state_q != StRun) && (32'(exp_idx_i) < DEPTH)) begin
      tbl_addr_q[exp_idx_i] <= exp_addr_i;
      tbl_data_q[exp_idx_i] <= exp_data_i;
    end
  end

  // Check FSM with registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_lat_q   <= '0;
      match_cnt_q <= '0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= 2'd0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
`ifdef MEMCHK_UNORDERED_EN
      mask_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StPass, StFail: begin
          if (start_i) begin
            cnt_lat_q   <= cnt_clamp;
            match_cnt_q <= '0;
            tmr_q       <= '0;
            fail_q      <= 1'b0;
            fail_code_q <= 2'd0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
`ifdef MEMCHK_UNORDERED_EN
            mask_q      <= '0;
`endif
            if (cnt_clamp == '0) begin
              state_q <= StPass;
              pass_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StRun;
              pass_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (memwrite_i && hit) begin
            match_cnt_q <= match_inc;
`ifdef MEMCHK_UNORDERED_EN
            mask_q[hit_idx] <= 1'b1;
`endif
          end
          if (memwrite_i && hit && (match_inc == cnt_lat_q)) begin
            state_q <= StPass;
            pass_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (memwrite_i && !hit && !ign_hit) begin
            state_q     <= StFail;
            fail_q      <= 1'b1;
            busy_q      <= 1'b0;
            fail_code_q <= 2'd1;
            fail_addr_q <= dataadr_i;
            fail_data_q <= writedata_i;
          end else if ((TIMEOUT != 0) && (tmr_q == TmrW'(TIMEOUT - 1))) begin
            // Timeout only fires when this cycle produced no pass/fail decision.
            state_q     <= StFail;
            fail_q      <= 1'b1;
            busy_q      <= 1'b0;
            fail_code_q <= 2'd2;
          end else if (TIMEOUT != 0) begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign fail_code_o = fail_code_q;
  assign match_cnt_o = match_cnt_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

endmodule
